// File: rtl/dm_store_ram.sv
// Word-organised data memory with little-endian byte/half/word store lane steering,
// combinational raw-word read, and a sticky first-fault alignment error latch.
module dm_store_ram #(
   parameter int ADDR_W = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [1:0]  st_op,
   input  logic [31:0] wd,
   input  logic        re,
   input  logic [1:0]  ld_sz,
   output logic [31:0] rd,
   output logic        aerr,
   output logic        aerr_st,
   output logic [31:0] badaddr,
   input  logic        err_clr
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0]       mem [0:DEPTH-1];
   logic [ADDR_W-1:0] widx;
   logic [1:0]        lane;
   logic              st_fault, ld_fault, fault;
   logic [3:0]        be;
   logic [31:0]       wdata;
   logic              unused_hi;

   assign widx = addr[ADDR_W+1:2];
   assign lane = addr[1:0];
   // high address bits are ignored, so accesses wrap modulo the array size
   assign unused_hi = ^addr[31:ADDR_W+2];

   assign st_fault = we && ((st_op == 2'b11) ||
                            (st_op == 2'b00 && lane != 2'b00) ||
                            (st_op == 2'b01 && lane[0]));
   assign ld_fault = re && ((ld_sz == 2'b11) ||
                            (ld_sz == 2'b00 && lane != 2'b00) ||
                            (ld_sz == 2'b01 && lane[0]));
   assign fault = st_fault || ld_fault;

   always_comb begin
      be    = 4'b0000;
      wdata = wd;
      case (st_op)
         2'b00: be = 4'b1111;
         2'b01: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{wd[15:0]}};
         end
         2'b10: begin
            wdata = {4{wd[7:0]}};
            case (lane)
               2'b00:   be = 4'b0001;
               2'b01:   be = 4'b0010;
               2'b10:   be = 4'b0100;
               default: be = 4'b1000;
            endcase
         end
         default: be = 4'b0000;
      endcase
      if (!we || st_fault) be = 4'b0000;
   end

   // a store coinciding with reset is dropped
   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rd = mem[widx];

   // a fresh fault beats a same-cycle clear; otherwise the first fault sticks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aerr    <= 1'b0;
         aerr_st <= 1'b0;
         badaddr <= 32'h0;
      end else if (fault && (!aerr || err_clr)) begin
         aerr    <= 1'b1;
         aerr_st <= st_fault;
         badaddr <= addr;
      end else if (err_clr) begin
         aerr    <= 1'b0;
         aerr_st <= 1'b0;
         badaddr <= 32'h0;
      end
   end

endmodule

// File: tb/tb_dm_store_ram.sv
// Directed self-checking bench for dm_store_ram: lane steering, alignment faults,
// first-fault latch, same-cycle read/write, address wrap and asynchronous reset.
module tb_dm_store_ram;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr;
   logic        we;
   logic [1:0]  st_op;
   logic [31:0] wd;
   logic        re;
   logic [1:0]  ld_sz;
   logic [31:0] rd;
   logic        aerr;
   logic        aerr_st;
   logic [31:0] badaddr;
   logic        err_clr;

   int n_chk  = 0;
   int n_fail = 0;

   dm_store_ram #(.ADDR_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .st_op(st_op), .wd(wd),
      .re(re), .ld_sz(ld_sz), .rd(rd), .aerr(aerr), .aerr_st(aerr_st),
      .badaddr(badaddr), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // advance past the next rising edge; inputs change and outputs are sampled here
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [1:0] op, input logic [31:0] d);
      addr = a; st_op = op; wd = d; we = 1'b1;
      step();
      we = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; addr = '0; we = 1'b0; st_op = '0; wd = '0;
      re = 1'b0; ld_sz = '0; err_clr = 1'b0;
      #12;
      chk("rst_aerr", {31'b0, aerr}, 32'h0);
      chk("rst_aerr_st", {31'b0, aerr_st}, 32'h0);
      chk("rst_badaddr", badaddr, 32'h0);
      rst_n = 1'b1;
      step();

      // word store then read
      store(32'h10, 2'b00, 32'h11223344);
      addr = 32'h10; #1;
      chk("sw_rd", rd, 32'h11223344);
      chk("sw_aerr", {31'b0, aerr}, 32'h0);

      // back-to-back SB then SH merge into the same word
      store(32'h11, 2'b10, 32'h000000AA);
      store(32'h12, 2'b01, 32'h0000BEEF);
      addr = 32'h10; #1;
      chk("lane_rd", rd, 32'hBEEFAA44);

      // misaligned SW is suppressed and latched as a store fault
      store(32'h20, 2'b00, 32'hCAFEF00D);
      addr = 32'h22; st_op = 2'b00; wd = 32'h99999999; we = 1'b1; #1;
      chk("mis_sw_pre", rd, 32'hCAFEF00D);
      step();
      we = 1'b0; #1;
      chk("mis_sw_rd", rd, 32'hCAFEF00D);
      chk("mis_sw_aerr", {31'b0, aerr}, 32'h1);
      chk("mis_sw_st", {31'b0, aerr_st}, 32'h1);
      chk("mis_sw_bad", badaddr, 32'h22);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("clr1_aerr", {31'b0, aerr}, 32'h0);

      // first fault wins: misaligned half load, then reserved store
      store(32'h40, 2'b00, 32'h01020304);
      addr = 32'h31; re = 1'b1; ld_sz = 2'b01;
      step();
      re = 1'b0;
      chk("ld_aerr", {31'b0, aerr}, 32'h1);
      chk("ld_st", {31'b0, aerr_st}, 32'h0);
      chk("ld_bad", badaddr, 32'h31);
      store(32'h40, 2'b11, 32'hFFFFFFFF);
      addr = 32'h40; #1;
      chk("rsv_nowrite", rd, 32'h01020304);
      chk("first_bad", badaddr, 32'h31);
      chk("first_st", {31'b0, aerr_st}, 32'h0);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("clr2_aerr", {31'b0, aerr}, 32'h0);
      chk("clr2_bad", badaddr, 32'h0);
      chk("clr2_st", {31'b0, aerr_st}, 32'h0);

      // same-cycle read returns old word, new word next cycle
      store(32'h08, 2'b00, 32'h12345678);
      addr = 32'h08; st_op = 2'b00; wd = 32'h5A5A5A5A; we = 1'b1; #1;
      chk("rw_old", rd, 32'h12345678);
      step();
      we = 1'b0; #1;
      chk("rw_new", rd, 32'h5A5A5A5A);

      // address wrap is silent
      store(32'h1004, 2'b00, 32'hDEADBEEF);
      addr = 32'h0004; #1;
      chk("wrap_rd", rd, 32'hDEADBEEF);
      chk("wrap_aerr", {31'b0, aerr}, 32'h0);

      // fault alongside clear is latched fresh; store beats load on a tie
      store(32'h51, 2'b01, 32'h0);
      chk("sh_bad", badaddr, 32'h51);
      chk("sh_st", {31'b0, aerr_st}, 32'h1);
      addr = 32'h62; re = 1'b1; ld_sz = 2'b00; err_clr = 1'b1;
      step();
      re = 1'b0; err_clr = 1'b0;
      chk("clrf_aerr", {31'b0, aerr}, 32'h1);
      chk("clrf_bad", badaddr, 32'h62);
      chk("clrf_st", {31'b0, aerr_st}, 32'h0);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      addr = 32'h71; we = 1'b1; st_op = 2'b00; re = 1'b1; ld_sz = 2'b11;
      step();
      we = 1'b0; re = 1'b0;
      chk("both_st", {31'b0, aerr_st}, 32'h1);
      chk("both_bad", badaddr, 32'h71);

      // asynchronous reset clears errors mid-cycle and drops a concurrent store
      #2 rst_n = 1'b0;
      #1;
      chk("arst_aerr", {31'b0, aerr}, 32'h0);
      chk("arst_bad", badaddr, 32'h0);
      addr = 32'h08; st_op = 2'b00; wd = 32'hFFFFFFFF; we = 1'b1;
      step();
      we = 1'b0; rst_n = 1'b1; #1;
      chk("arst_nowrite", rd, 32'h5A5A5A5A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
